sim_ctrl_monitor: RTL and testbench

SIM_CTRL_MONITOR -- requirements
Module: sim_ctrl_monitor

---
 rtl/sim_ctrl_pkg.sv | 22 ++
 rtl/sim_ctrl_exit_latch.sv | 31 +++
 rtl/sim_ctrl_monitor.sv | 127 ++++++++++++
 tb/tb_sim_ctrl_monitor.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types and default constants for the simulation control monitor.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sim_ctrl_state_e;

  localparam int DEF_NUM_CH            = 2;
  localparam int DEF_RESET_WAIT_CYCLES = 50;
  localparam int DEF_CNT_W             = 32;
  localparam int DEF_EXIT_W            = 32;
  localparam int HOLD_CNT_W            = 16;

  // Channel index width, never narrower than one bit.
  function automatic int fidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_ctrl_exit_latch.sv
// One exit channel: sticky exited flag plus the value carried by its first strobe.
module sim_ctrl_exit_latch #(
  parameter int EXIT_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [EXIT_W-1:0] i_value,
  output logic              o_exited,
  output logic [EXIT_W-1:0] o_value
);

  logic              r_exited;
  logic [EXIT_W-1:0] r_value;

  // Once set, the flag blocks any later strobe from replacing the value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exited <= 1'b0;
      r_value  <= '0;
    end else if (i_en && i_valid && !r_exited) begin
      r_exited <= 1'b1;
      r_value  <= i_value;
    end
  end

  assign o_exited = r_exited;
  assign o_value  = r_value;

endmodule

// File: rtl/sim_ctrl_monitor.sv
// Arms a managed reset, counts run cycles and collects per-channel exit codes into a verdict.
module sim_ctrl_monitor
  import sim_ctrl_pkg::*;
#(
  parameter int NUM_CH            = DEF_NUM_CH,
  parameter int RESET_WAIT_CYCLES = DEF_RESET_WAIT_CYCLES,
  parameter int CNT_W             = DEF_CNT_W,
  parameter int EXIT_W            = DEF_EXIT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         timeout_en_i,
  input  logic [CNT_W-1:0]             max_cycles_i,
  input  logic [NUM_CH-1:0]            exit_valid_i,
  input  logic [NUM_CH*EXIT_W-1:0]     exit_value_i,
  output logic                         sys_rst_no,
  output logic [CNT_W-1:0]             cycle_cnt_o,
  output logic [NUM_CH-1:0]            exited_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic                         timeout_o,
  output logic [fidx_width(NUM_CH)-1:0] fail_idx_o,
  output logic [EXIT_W-1:0]            fail_value_o
);

  localparam int FIDX_W = fidx_width(NUM_CH);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RESET_WAIT_CYCLES - 1);

  sim_ctrl_state_e         r_state;
  sim_ctrl_state_e         w_next;
  logic [HOLD_CNT_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_timeout;
  logic                    r_sys_rst_n;
  logic [NUM_CH-1:0]       w_exited;
  logic [EXIT_W-1:0]       w_lat_val [NUM_CH];
  logic                    w_run;
  logic                    w_all_exit;
  logic                    w_to_hit;
  logic                    w_found;
  logic [FIDX_W-1:0]       w_fail_idx;
  logic [EXIT_W-1:0]       w_fail_val;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_run      = (r_state == ST_RUN);
  // Same-cycle strobes count toward completion so the last exit ends the run at once.
  assign w_all_exit = &(w_exited | exit_valid_i);
  assign w_to_hit   = w_run && !w_all_exit && timeout_en_i && (r_cnt >= max_cycles_i);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      sim_ctrl_exit_latch #(
        .EXIT_W (EXIT_W)
      ) u_latch (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_en     (w_run),
        .i_valid  (exit_valid_i[g]),
        .i_value  (exit_value_i[g*EXIT_W +: EXIT_W]),
        .o_exited (w_exited[g]),
        .o_value  (w_lat_val[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_next = ST_HOLD;
      ST_HOLD: if (r_hold_cnt == HOLD_LAST) w_next = ST_RUN;
      ST_RUN:  if (w_all_exit || w_to_hit) w_next = ST_DONE;
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  // The run counter only advances while staying in RUN, so DONE shows the deciding cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold_cnt  <= '0;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
      r_sys_rst_n <= 1'b0;
    end else begin
      r_sys_rst_n <= (w_next == ST_RUN) || (w_next == ST_DONE);
      if (r_state == ST_IDLE && start_i)  r_hold_cnt <= '0;
      else if (r_state == ST_HOLD)        r_hold_cnt <= r_hold_cnt + 1'b1;
      if (r_state == ST_HOLD)             r_cnt <= '0;
      else if (w_run && w_next == ST_RUN) r_cnt <= sat_inc(r_cnt);
      if (w_to_hit)                       r_timeout <= 1'b1;
    end
  end

  // Scanning from the top down leaves the lowest non-zero channel as the winner.
  always_comb begin
    w_found    = 1'b0;
    w_fail_idx = '0;
    w_fail_val = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_lat_val[k] != '0) begin
        w_found    = 1'b1;
        w_fail_idx = FIDX_W'(k);
        w_fail_val = w_lat_val[k];
      end
    end
  end

  assign sys_rst_no   = r_sys_rst_n;
  assign cycle_cnt_o  = r_cnt;
  assign exited_o     = w_exited;
  assign done_o       = (r_state == ST_DONE);
  assign timeout_o    = r_timeout;
  assign pass_o       = done_o && !r_timeout && !w_found;
  assign fail_idx_o   = (done_o && !r_timeout && w_found) ? w_fail_idx : '0;
  assign fail_value_o = (done_o && !r_timeout && w_found) ? w_fail_val : '0;

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// Scenario bench for sim_ctrl_monitor with a schedule-level reference model.
module tb_sim_ctrl_monitor;

  localparam int NCH   = 2;
  localparam int RWC   = 50;
  localparam int NEVER = 1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            timeout_en = 1'b0;
  logic [31:0]     max_cycles = '0;
  logic [NCH-1:0]  exit_valid = '0;
  logic [NCH*32-1:0] exit_value = '0;
  logic            sys_rst_n;
  logic [31:0]     cnt;
  logic [NCH-1:0]  exited;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [0:0]      fail_idx;
  logic [31:0]     fail_value;

  int n_vec = 0;
  int n_err = 0;

  // Exit schedule: per channel up to three strobes at ascending RUN-cycle indices.
  int          ev_cyc [NCH][3];
  logic [31:0] ev_val [NCH][3];
  bit          s_to_en;
  int          s_max;

  sim_ctrl_monitor #(
    .NUM_CH            (NCH),
    .RESET_WAIT_CYCLES (RWC),
    .CNT_W             (32),
    .EXIT_W            (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .timeout_en_i (timeout_en),
    .max_cycles_i (max_cycles),
    .exit_valid_i (exit_valid),
    .exit_value_i (exit_value),
    .sys_rst_no   (sys_rst_n),
    .cycle_cnt_o  (cnt),
    .exited_o     (exited),
    .done_o       (done),
    .pass_o       (pass),
    .timeout_o    (timeout),
    .fail_idx_o   (fail_idx),
    .fail_value_o (fail_value)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; exit_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_never();
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < 3; j++) begin
        ev_cyc[k][j] = NEVER;
        ev_val[k][j] = '0;
      end
    s_to_en = 1'b0;
    s_max   = 0;
  endtask

  // Arm from IDLE and verify the hold window; stray starts and exits are injected along the way.
  task automatic arm(input string tag);
    exit_valid = '1; exit_value = {32'h11, 32'h22}; start = 1'b1;
    tick();
    start = 1'b0; exit_valid = '0;
    for (int i = 0; i < RWC; i++) begin
      n_vec++;
      if (sys_rst_n !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold_rst_n[%0d]: got %b want 0", tag, i, sys_rst_n);
      end
      if (i == 20) begin start = 1'b1; exit_valid = '1; end
      tick();
      start = 1'b0; exit_valid = '0;
    end
    n_vec++;
    if (sys_rst_n !== 1'b1) begin
      n_err++; $display("FAIL %s run_entry_rst_n: got %b want 1", tag, sys_rst_n);
    end
    n_vec++;
    if (cnt !== 32'd0) begin
      n_err++; $display("FAIL %s run_entry_cnt: got %0d want 0", tag, cnt);
    end
    n_vec++;
    if (exited !== '0) begin
      n_err++; $display("FAIL %s run_entry_exited: got %b want 0", tag, exited);
    end
  endtask

  task automatic run_case(input string name);
    int          first [NCH];
    int          c, s;
    bit          e_to, e_pass;
    logic [NCH-1:0] e_ex;
    logic [0:0]  e_idx;
    logic [31:0] e_val;
    // Reference: run ends at the later first exit, or earlier at the cycle limit.
    c = 0;
    for (int k = 0; k < NCH; k++) begin
      first[k] = ev_cyc[k][0];
      if (first[k] > c) c = first[k];
    end
    e_to = s_to_en && (s_max < c);
    s    = e_to ? s_max : c;
    e_pass = !e_to;
    e_idx  = '0;
    e_val  = '0;
    for (int k = 0; k < NCH; k++) begin
      e_ex[k] = (first[k] <= s);
      if (ev_val[k][0] != 0) e_pass = 1'b0;
    end
    if (!e_pass && !e_to)
      for (int k = NCH - 1; k >= 0; k--)
        if (ev_val[k][0] != 0) begin e_idx = 1'(k); e_val = ev_val[k][0]; end

    do_reset();
    timeout_en = s_to_en;
    max_cycles = 32'(s_max);
    arm(name);
    for (int t = 0; t <= s + 5; t++) begin
      exit_valid = '0;
      exit_value = '0;
      for (int k = 0; k < NCH; k++)
        for (int j = 0; j < 3; j++)
          if (ev_cyc[k][j] == t) begin
            exit_valid[k] = 1'b1;
            exit_value[k*32 +: 32] = ev_val[k][j];
          end
      start = (t == s + 2);
      if (t <= s) begin
        n_vec++;
        if (cnt !== 32'(t)) begin
          n_err++; $display("FAIL %s cnt[%0d]: got %0d want %0d", name, t, cnt, t);
        end
      end
      tick();
      n_vec++;
      if (done !== (t >= s)) begin
        n_err++; $display("FAIL %s done[%0d]: got %b want %b", name, t, done, (t >= s));
      end
    end
    start = 1'b0; exit_valid = '0;
    n_vec++;
    if (cnt !== 32'(s)) begin
      n_err++; $display("FAIL %s frozen_cnt: got %0d want %0d", name, cnt, s);
    end
    n_vec++;
    if (timeout !== e_to) begin
      n_err++; $display("FAIL %s timeout: got %b want %b", name, timeout, e_to);
    end
    n_vec++;
    if (pass !== e_pass) begin
      n_err++; $display("FAIL %s pass: got %b want %b", name, pass, e_pass);
    end
    n_vec++;
    if (exited !== e_ex) begin
      n_err++; $display("FAIL %s exited: got %b want %b", name, exited, e_ex);
    end
    n_vec++;
    if (fail_idx !== e_idx || fail_value !== e_val) begin
      n_err++;
      $display("FAIL %s fail_info: got idx %0d val %h want idx %0d val %h",
               name, fail_idx, fail_value, e_idx, e_val);
    end
    n_vec++;
    if (sys_rst_n !== 1'b1) begin
      n_err++; $display("FAIL %s done_rst_n: got %b want 1", name, sys_rst_n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({sys_rst_n, cnt, exited, done, pass, timeout, fail_idx, fail_value} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got rst_n=%b cnt=%0d ex=%b done=%b pass=%b to=%b idx=%0d val=%h want all 0",
               sys_rst_n, cnt, exited, done, pass, timeout, fail_idx, fail_value);
    end
    exit_valid = '1; exit_value = {32'h0, 32'h0};
    for (int i = 0; i < 5; i++) tick();
    exit_valid = '0;
    n_vec++;
    if (sys_rst_n !== 1'b0 || exited !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_quiet: got rst_n=%b ex=%b done=%b want 0 0 0", sys_rst_n, exited, done);
    end
  endtask

  task automatic test_pass();
    set_never();
    ev_cyc[0][0] = 10; ev_cyc[1][0] = 20;
    run_case("pass");
  endtask

  task automatic test_fail();
    set_never();
    ev_cyc[1][0] = 2; ev_val[1][0] = 32'h5;
    ev_cyc[0][0] = 5; ev_val[0][0] = 32'h3;
    ev_cyc[1][1] = 8; ev_val[1][1] = 32'h0;
    run_case("fail");
    set_never();
    ev_cyc[1][0] = 2; ev_val[1][0] = 32'h5;
    ev_cyc[1][1] = 4; ev_val[1][1] = 32'h0;
    ev_cyc[0][0] = 6; ev_val[0][0] = 32'h0;
    run_case("first_exit_wins");
  endtask

  task automatic test_timeout();
    set_never();
    s_to_en = 1'b1; s_max = 100;
    run_case("timeout_100");
    set_never();
    s_to_en = 1'b1; s_max = 0;
    run_case("timeout_0");
    set_never();
    s_to_en = 1'b1; s_max = 12;
    ev_cyc[0][0] = 4; ev_val[0][0] = 32'h9;
    run_case("timeout_partial");
  endtask

  task automatic test_tie();
    set_never();
    s_to_en = 1'b1; s_max = 30;
    ev_cyc[0][0] = 3; ev_cyc[1][0] = 30; ev_val[1][0] = 32'h7;
    run_case("tie_fail");
    set_never();
    s_to_en = 1'b1; s_max = 30;
    ev_cyc[0][0] = 30; ev_cyc[1][0] = 30;
    run_case("tie_pass");
  endtask

  task automatic test_mid_run_reset();
    do_reset();
    timeout_en = 1'b0;
    arm("midrst_arm1");
    for (int t = 0; t < 37; t++) tick();
    n_vec++;
    if (cnt !== 32'd37) begin
      n_err++; $display("FAIL midrst_cnt: got %0d want 37", cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({sys_rst_n, cnt, exited, done, pass, timeout, fail_idx, fail_value} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got rst_n=%b cnt=%0d ex=%b done=%b want all 0",
               sys_rst_n, cnt, exited, done);
    end
    arm("midrst_arm2");
    tick(); tick();
    n_vec++;
    if (cnt !== 32'd2) begin
      n_err++; $display("FAIL midrst_rerun_cnt: got %0d want 2", cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      set_never();
      for (int k = 0; k < NCH; k++) begin
        ev_cyc[k][0] = $urandom_range(0, 40);
        ev_cyc[k][1] = ev_cyc[k][0] + 1 + $urandom_range(0, 5);
        ev_cyc[k][2] = ev_cyc[k][1] + 1 + $urandom_range(0, 5);
        ev_val[k][0] = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom_range(1, 15));
        ev_val[k][1] = $urandom;
        ev_val[k][2] = $urandom;
      end
      s_to_en = ($urandom_range(0, 1) == 1);
      s_max   = $urandom_range(0, 60);
      run_case($sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_tie();
    test_mid_run_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
